// File: rtl/score_overlay.sv
// score_overlay
// Draws a binary score as DIGITS seven-segment glyphs on the VGA pixel path.
// Once per frame the score is converted to BCD by a serial double-dabble
// engine. The displayed digits change only at commit, so a frame is never
// drawn with a half-updated value.
//
// Ports:
//   clk, reset    system clock, synchronous active-high reset
//   ce            pixel clock enable; all non-reset state advances only when 1
//   x, y          current pixel coordinate (10 bits each)
//   frame_start   one-ce-cycle pulse at the start of vertical blanking
//   score         binary score to display
//   blank_lz      1 = blank leading zeros
//   colour_out    registered pixel colour (2 ce-cycle latency)
//   hit           registered "pixel lies inside a digit cell" flag
//   busy          conversion in progress
//   overflow      committed score does not fit in DIGITS decimal digits
module score_overlay #(
    parameter int          DIGITS       = 4,
    parameter int          SCORE_W      = 16,
    parameter int          X0           = 50,
    parameter int          Y0           = 139,
    parameter int          SEG_LEN      = 10,
    parameter int          SEG_T        = 5,
    parameter int          PITCH        = 25,
    parameter logic [11:0] FG           = 12'hFFF,
    parameter logic [11:0] BG           = 12'h000,
    parameter logic [11:0] FLASH_COL    = 12'h0FF,
    parameter int          FLASH_FRAMES = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ce,
    input  logic [9:0]         x,
    input  logic [9:0]         y,
    input  logic               frame_start,
    input  logic [SCORE_W-1:0] score,
    input  logic               blank_lz,
    output logic [11:0]        colour_out,
    output logic               hit,
    output logic               busy,
    output logic               overflow
);

    localparam int W = 2*SEG_T + SEG_LEN;
    localparam int H = 3*SEG_T + 2*SEG_LEN;

    // Number of decimal digits needed to hold 2^w-1.
    function automatic int dec_digits(input int w);
        longint v;
        int     n;
        v = (longint'(1) << w) - 1;
        n = 0;
        while (v != 0) begin
            n++;
            v = v / 10;
        end
        return (n < 1) ? 1 : n;
    endfunction

    // The BCD register is never narrower than the display, so the overflow
    // test only has to look at the digits above DIGITS.
    localparam int NB_MIN = dec_digits(SCORE_W);
    localparam int NB     = (NB_MIN > DIGITS) ? NB_MIN : DIGITS;
    localparam int CNT_W  = $clog2(SCORE_W + 1);
    localparam int FC_W   = $clog2(FLASH_FRAMES + 2);
    localparam int DI_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t              state, state_nxt;
    logic [SCORE_W-1:0]  score_cap;
    logic [SCORE_W-1:0]  bin_sh;
    logic [SCORE_W-1:0]  shown;
    logic [4*NB-1:0]     bcd;
    logic [CNT_W-1:0]    iter;
    logic [3:0]          disp [DIGITS];
    logic [FC_W-1:0]     flash_cnt;
    logic                flashing;
    logic [DIGITS-1:0]   blank;

    // Double-dabble correction: add 3 to every BCD digit that is 5 or more
    // so the following left shift carries correctly into the next digit.
    function automatic logic [4*NB-1:0] dabble_adj(input logic [4*NB-1:0] b);
        logic [4*NB-1:0] r;
        r = b;
        for (int i = 0; i < NB; i++) begin
            if (r[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Saturation test: any nonzero digit above the displayed ones.
    function automatic logic bcd_overflow(input logic [4*NB-1:0] b);
        logic o;
        o = 1'b0;
        for (int i = DIGITS; i < NB; i++)
            o = o | (b[4*i +: 4] != 4'd0);
        return o;
    endfunction

    // Segment pattern, bit order {a,b,c,d,e,f,g}.
    function automatic logic [6:0] seg_pattern(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h7E;
            4'd1:    p = 7'h30;
            4'd2:    p = 7'h6D;
            4'd3:    p = 7'h79;
            4'd4:    p = 7'h33;
            4'd5:    p = 7'h5B;
            4'd6:    p = 7'h5F;
            4'd7:    p = 7'h70;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h7B;
            default: p = 7'h00;
        endcase
        return p;
    endfunction

    // Is local pixel (lx, ly) inside any segment enabled in pattern p?
    function automatic logic seg_lit(input logic [9:0] lx, input logic [9:0] ly,
                                     input logic [6:0] p);
        int   cx, cy;
        logic left, right, upper, lower;
        cx    = int'(lx);
        cy    = int'(ly);
        left  = (cx < SEG_T);
        right = (cx >= W - SEG_T);
        upper = (cy < 2*SEG_T + SEG_LEN);
        lower = (cy >= SEG_T + SEG_LEN);
        return (p[6] && (cy < SEG_T))
            || (p[5] && right && upper)
            || (p[4] && right && lower)
            || (p[3] && (cy >= 2*SEG_T + 2*SEG_LEN))
            || (p[2] && left && lower)
            || (p[1] && left && upper)
            || (p[0] && (cy >= SEG_T + SEG_LEN) && (cy < 2*SEG_T + SEG_LEN));
    endfunction

    // Conversion FSM
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else if (ce)
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame_start && (score != shown)) state_nxt = SHIFT;
            SHIFT:   if (iter == CNT_W'(SCORE_W - 1))     state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Serial binary-to-BCD datapath; fully reloaded at every capture.
    always_ff @(posedge clk) begin
        if (ce) begin
            case (state)
                IDLE: begin
                    if (state_nxt == SHIFT) begin
                        score_cap <= score;
                        bin_sh    <= score;
                        bcd       <= '0;
                        iter      <= '0;
                    end
                end
                SHIFT: begin
                    {bcd, bin_sh} <= {dabble_adj(bcd), bin_sh} << 1;
                    iter          <= iter + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Commit: digits, shown value and overflow change together.
    always_ff @(posedge clk) begin
        if (reset) begin
            shown    <= '0;
            overflow <= 1'b0;
            for (int k = 0; k < DIGITS; k++)
                disp[k] <= 4'd0;
        end else if (ce && (state == COMMIT)) begin
            shown    <= score_cap;
            overflow <= bcd_overflow(bcd);
            for (int k = 0; k < DIGITS; k++)
                disp[k] <= bcd_overflow(bcd) ? 4'd9 : bcd[4*(DIGITS-1-k) +: 4];
        end
    end

    // Flash counter: a commit reload wins over a same-cycle frame decrement.
    always_ff @(posedge clk) begin
        if (reset)
            flash_cnt <= '0;
        else if (ce) begin
            if (state == COMMIT)
                flash_cnt <= FC_W'(FLASH_FRAMES);
            else if (frame_start && (flash_cnt != '0))
                flash_cnt <= flash_cnt - FC_W'(1);
        end
    end

    assign flashing = (flash_cnt != '0) && flash_cnt[0];

    // Leading-zero mask; the least-significant digit is never blanked.
    always_comb begin
        logic lead;
        blank = '0;
        lead  = blank_lz && !overflow;
        for (int k = 0; k < DIGITS - 1; k++) begin
            lead     = lead && (disp[k] == 4'd0);
            blank[k] = lead;
        end
    end

    // ---- Stage 1: parallel digit-window compare ----
    logic [DI_W-1:0] dig_c,  dig_p1;
    logic [9:0]      lx_c,   lx_p1;
    logic [9:0]      ly_c,   ly_p1;
    logic            cell_c, hit_p1;
    int              xi, yi;

    always_comb begin
        xi     = int'(x);
        yi     = int'(y);
        dig_c  = '0;
        lx_c   = '0;
        cell_c = 1'b0;
        ly_c   = 10'(yi - Y0);
        for (int k = 0; k < DIGITS; k++) begin
            if ((xi >= X0 + k*PITCH) && (xi < X0 + k*PITCH + W)) begin
                cell_c = 1'b1;
                dig_c  = DI_W'(k);
                lx_c   = 10'(xi - (X0 + k*PITCH));
            end
        end
        cell_c = cell_c && (yi >= Y0) && (yi < Y0 + H);
    end

    always_ff @(posedge clk) begin
        if (reset)
            hit_p1 <= 1'b0;
        else if (ce)
            hit_p1 <= cell_c;
    end

    always_ff @(posedge clk) begin
        if (ce) begin
            dig_p1 <= dig_c;
            lx_p1  <= lx_c;
            ly_p1  <= ly_c;
        end
    end

    // ---- Stage 2: glyph lookup and colour ----
    logic [3:0] d_sel;
    logic       blk_sel;
    logic       lit_p1;

    always_comb begin
        d_sel   = 4'd0;
        blk_sel = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (dig_p1 == DI_W'(k)) begin
                d_sel   = disp[k];
                blk_sel = blank[k];
            end
        end
        lit_p1 = hit_p1 && !blk_sel && seg_lit(lx_p1, ly_p1, seg_pattern(d_sel));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            colour_out <= BG;
            hit        <= 1'b0;
        end else if (ce) begin
            hit        <= hit_p1;
            colour_out <= lit_p1 ? (flashing ? FLASH_COL : FG) : BG;
        end
    end

endmodule

// File: tb/tb_score_overlay.sv
// Bench for score_overlay: directed steps plus randomized scores and pixels,
// checked against a decimal-arithmetic model of the scoreboard display.
module tb_score_overlay;

    localparam int          DIGITS       = 4;
    localparam int          SCORE_W      = 16;
    localparam int          X0           = 50;
    localparam int          Y0           = 139;
    localparam int          SEG_LEN      = 10;
    localparam int          SEG_T        = 5;
    localparam int          PITCH        = 25;
    localparam logic [11:0] FG           = 12'hFFF;
    localparam logic [11:0] BG           = 12'h000;
    localparam logic [11:0] FLASH_COL    = 12'h0FF;
    localparam int          FLASH_FRAMES = 8;
    localparam int          W            = 2*SEG_T + SEG_LEN;
    localparam int          H            = 3*SEG_T + 2*SEG_LEN;

    logic               clk = 1'b0;
    logic               reset, ce, frame_start, blank_lz;
    logic [9:0]         x, y;
    logic [SCORE_W-1:0] score;
    logic [11:0]        colour_out;
    logic               hit, busy, overflow;

    score_overlay #(
        .DIGITS(DIGITS), .SCORE_W(SCORE_W), .X0(X0), .Y0(Y0),
        .SEG_LEN(SEG_LEN), .SEG_T(SEG_T), .PITCH(PITCH),
        .FG(FG), .BG(BG), .FLASH_COL(FLASH_COL), .FLASH_FRAMES(FLASH_FRAMES)
    ) dut (
        .clk(clk), .reset(reset), .ce(ce), .x(x), .y(y),
        .frame_start(frame_start), .score(score), .blank_lz(blank_lz),
        .colour_out(colour_out), .hit(hit), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model state: value on screen, overflow flag, flash counter.
    int m_shown = 0;
    bit m_ovf   = 1'b0;
    int m_flash = 0;

    string segs [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                         "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic bit in_seg(input byte s, input int lx, input int ly);
        case (s)
            "a": return ly < SEG_T;
            "b": return (lx >= W - SEG_T) && (ly < 2*SEG_T + SEG_LEN);
            "c": return (lx >= W - SEG_T) && (ly >= SEG_T + SEG_LEN);
            "d": return ly >= 2*SEG_T + 2*SEG_LEN;
            "e": return (lx < SEG_T) && (ly >= SEG_T + SEG_LEN);
            "f": return (lx < SEG_T) && (ly < 2*SEG_T + SEG_LEN);
            "g": return (ly >= SEG_T + SEG_LEN) && (ly < 2*SEG_T + SEG_LEN);
            default: return 1'b0;
        endcase
    endfunction

    // Expected colour/hit for a pixel given the model's displayed number.
    task automatic ref_pix(input int px, input int py,
                           output logic [11:0] col, output logic h);
        int lx, ly, place, d;
        bit lit, blanked;
        col = BG;
        h   = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            lx = px - (X0 + k*PITCH);
            ly = py - Y0;
            if (lx >= 0 && lx < W && ly >= 0 && ly < H) begin
                h       = 1'b1;
                place   = pow10(DIGITS - 1 - k);
                d       = m_ovf ? 9 : (m_shown / place) % 10;
                blanked = blank_lz && !m_ovf && (k < DIGITS - 1) && (m_shown / place == 0);
                lit     = 1'b0;
                for (int i = 0; i < segs[d].len(); i++)
                    if (in_seg(segs[d][i], lx, ly)) lit = 1'b1;
                if (lit && !blanked)
                    col = (m_flash != 0 && (m_flash % 2) == 1) ? FLASH_COL : FG;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a pixel, wait out the two-stage latency, compare with the model.
    task automatic check_pix(input int px, input int py, input string tag);
        logic [11:0] col;
        logic        h;
        x  = 10'(px);
        y  = 10'(py);
        ce = 1'b1;
        tick();
        tick();
        ref_pix(px, py, col, h);
        check({tag, "_col"}, 32'(colour_out), 32'(col));
        check({tag, "_hit"}, 32'(hit), 32'(h));
    endtask

    // One frame_start pulse; measures busy length and updates the model.
    task automatic frame(input int s, input string tag);
        bit conv;
        int cnt;
        conv        = (s != m_shown);
        score       = SCORE_W'(s);
        ce          = 1'b1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        if (m_flash != 0) m_flash--;
        cnt = 0;
        for (int i = 0; i < 40 && busy; i++) begin
            cnt++;
            tick();
        end
        check({tag, "_busy_cycles"}, 32'(cnt), conv ? 32'(SCORE_W + 1) : 32'd0);
        if (conv) begin
            m_shown = s;
            m_ovf   = (s >= pow10(DIGITS));
            m_flash = FLASH_FRAMES;
        end
        check({tag, "_overflow"}, 32'(overflow), 32'(m_ovf));
    endtask

    initial begin
        int px_prev, px, py, s, nf;
        logic [11:0] ec;
        logic        eh;

        reset = 1'b1; ce = 1'b1; frame_start = 1'b0; blank_lz = 1'b1;
        x = '0; y = '0; score = '0;
        tick(); tick(); tick();
        check("rst_col", 32'(colour_out), 32'(BG));
        check("rst_hit", 32'(hit), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        reset = 1'b0;

        // Score 0 equals the reset value: nothing to convert.
        frame(0, "zero");
        check_pix(X0 + 3*PITCH + SEG_T, Y0, "zero_lsd");
        check_pix(X0, Y0, "zero_msd_blank");
        check_pix(X0 + W, Y0, "zero_gap");

        blank_lz = 1'b0;
        frame(1234, "s1234");
        check_pix(X0 + PITCH + SEG_T, Y0 + SEG_T + SEG_LEN, "s1234_g_of_2");
        check_pix(X0 + 1, Y0 + SEG_T + 1, "s1234_f_of_1");
        check_pix(X0 + 2*PITCH + W - 1, Y0 + H - 1, "s1234_c_of_3");

        frame(12345, "s12345");
        check_pix(X0 + SEG_T + 1, Y0, "ovf_a_d0");
        check_pix(X0 + 3*PITCH + W - 1, Y0 + SEG_T + 1, "ovf_b_d3");
        check_pix(X0 + PITCH + 1, Y0 + H - 1, "ovf_e_d1");
        blank_lz = 1'b1;
        check_pix(X0 + SEG_T + 1, Y0, "ovf_no_blank");

        frame(42, "s42");
        check_pix(X0 + SEG_T + 1, Y0, "s42_d0_blank");
        check_pix(X0 + PITCH + SEG_T + 1, Y0, "s42_d1_blank");
        check_pix(X0 + 2*PITCH + 1, Y0 + SEG_T + 1, "s42_f_of_4");
        blank_lz = 1'b0;
        check_pix(X0 + SEG_T + 1, Y0, "s42_d0_shown");

        // Flash sequence on a lit pixel of the final '2'.
        for (int f = 0; f <= FLASH_FRAMES; f++) begin
            check_pix(X0 + 3*PITCH + SEG_T + 1, Y0 + 1, $sformatf("flash%0d", f));
            if (f < FLASH_FRAMES) frame(42, "flash_frame");
        end

        // ce toggling sweep: each output matches the pixel two ce-edges back
        // and holds while ce is low.
        py = Y0 + 1;
        px_prev = 0;
        for (int i = 0; i < 40; i++) begin
            px = X0 - 4 + i*3;
            x  = 10'(px);
            y  = 10'(py);
            ce = 1'b1;
            tick();
            ref_pix(px_prev, py, ec, eh);
            if (i > 0) begin
                check("sweep_col", 32'(colour_out), 32'(ec));
                check("sweep_hit", 32'(hit), 32'(eh));
            end
            ce = 1'b0;
            x  = 10'($urandom_range(0, 1023));
            y  = 10'($urandom_range(0, 1023));
            tick();
            if (i > 0) begin
                check("hold_col", 32'(colour_out), 32'(ec));
                check("hold_hit", 32'(hit), 32'(eh));
            end
            px_prev = px;
        end
        ce = 1'b1;

        // Randomized scores, frames and pixels.
        for (int r = 0; r < 8; r++) begin
            s = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10000, 65535))
                                            : int'($urandom_range(0, 9999));
            blank_lz = 1'($urandom_range(0, 1));
            frame(s, "rnd");
            nf = int'($urandom_range(0, 3));
            for (int j = 0; j < nf; j++) frame(s, "rnd_extra");
            for (int j = 0; j < 8; j++) begin
                if (j < 6)
                    check_pix(X0 + int'($urandom_range(0, DIGITS - 1))*PITCH + int'($urandom_range(0, W - 1)),
                              Y0 + int'($urandom_range(0, H - 1)), "rnd_cell");
                else
                    check_pix(X0 - 3 + int'($urandom_range(0, DIGITS*PITCH)),
                              Y0 - 2 + int'($urandom_range(0, H + 3)), "rnd_any");
            end
        end

        // Reset during the SHIFT phase aborts the conversion.
        blank_lz = 1'b0;
        frame(1, "pre_abort");
        score       = SCORE_W'(999);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick(); tick(); tick(); tick();
        reset = 1'b1;
        tick();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ovf", 32'(overflow), 32'd0);
        check("abort_col", 32'(colour_out), 32'(BG));
        check("abort_hit", 32'(hit), 32'd0);
        reset   = 1'b0;
        m_shown = 0;
        m_ovf   = 1'b0;
        m_flash = 0;
        check_pix(X0 + SEG_T + 1, Y0, "abort_d0_zero");
        check_pix(X0 + 3*PITCH + 1, Y0 + SEG_T + 1, "abort_d3_zero");
        frame(999, "s999");
        check_pix(X0 + PITCH + SEG_T + 1, Y0 + SEG_T + SEG_LEN, "s999_g_d1");
        check_pix(X0 + 3*PITCH + 1, Y0 + H - 1, "s999_e_d3");
        blank_lz = 1'b1;
        check_pix(X0 + SEG_T + 1, Y0, "s999_d0_blank");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
